pcie_ss_flr_responder: RTL and testbench

// - Application-side endpoint of the PCIe SS FLR interface; completes each FLR the subsystem requests.
// - Queues FLR requests, resets the target PF/VF in the AFU, waits for the AFU to quiesce, then returns the FLR response.
// - Sits in the FIM clock domain between the PCIe SS top and the AFU per-function reset logic.
// - One instance per PCIe link.

---
 rtl/pcie_ss_axis_pkg.sv | 16 +
 rtl/pcie_ss_flr_responder_pkg.sv | 8 +
 rtl/pcie_ss_flr_req_fifo.sv | 44 ++++
 rtl/pcie_ss_flr_responder.sv | 100 ++++++++++
 tb/tb_pcie_ss_flr_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_ss_axis_pkg.sv
// pcie_ss_axis_pkg: PCIe SS FLR sideband stream types shared by FIM blocks.
package pcie_ss_axis_pkg;
    localparam int PF_W = 3;
    localparam int VF_W = 11;

    typedef struct packed {
        logic            vf_active;
        logic [PF_W-1:0] pf;
        logic [VF_W-1:0] vf;
    } t_flr_func;

    typedef struct packed {
        logic      tvalid;
        t_flr_func tdata;
    } t_axis_pcie_flr;
endpackage

// File: rtl/pcie_ss_flr_responder_pkg.sv
// pcie_ss_flr_responder_pkg: FSM encoding and widths for the FLR responder.
package pcie_ss_flr_responder_pkg;
    import pcie_ss_axis_pkg::*;

    localparam int FUNC_W = $bits(t_flr_func);

    typedef enum logic [1:0] {IDLE, ASSERT, RESP} t_flr_rsp_state;
endpackage

// File: rtl/pcie_ss_flr_req_fifo.sv
// pcie_ss_flr_req_fifo: small synchronous FIFO holding pending FLR targets.
module pcie_ss_flr_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/pcie_ss_flr_responder.sv
// pcie_ss_flr_responder: queues PCIe SS FLR requests, drives the AFU per-function
// reset until it quiesces (or times out), then returns the FLR completion.
module pcie_ss_flr_responder
    import pcie_ss_axis_pkg::*;
    import pcie_ss_flr_responder_pkg::*;
#(
    parameter int REQ_FIFO_DEPTH = 4,
    parameter int MIN_RST_CYCLES = 16,
    parameter int ACK_TIMEOUT    = 65536
) (
    input  logic            fim_clk,
    input  logic            fim_rst_n,
    input  t_axis_pcie_flr  flr_req_if,
    output t_axis_pcie_flr  flr_rsp_if,
    output logic            afu_flr_rst_valid,
    output logic            afu_flr_rst_vf_active,
    output logic [PF_W-1:0] afu_flr_rst_pf,
    output logic [VF_W-1:0] afu_flr_rst_vf,
    input  logic            afu_flr_rst_ack,
    output logic            flr_busy,
    input  logic            clr_stat,
    output logic            stat_ovf,
    output logic            stat_timeout,
    output logic [7:0]      stat_timeout_cnt
);
    localparam int HW = $clog2(MIN_RST_CYCLES) + 1;
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(ACK_TIMEOUT - 1);

    t_flr_rsp_state state_q, state_d;
    t_flr_func      tgt_q, tgt_d, head;
    logic [HW-1:0]  hold_q, hold_d;
    logic [TW-1:0]  to_q, to_d;
    logic           ack_seen_q, ack_seen_d;
    logic           ovf_q, ovf_d, tmo_q, tmo_d;
    logic [7:0]     tcnt_q, tcnt_d;
    logic           full, empty, pop, drop, in_assert, ack_exit, to_exit;

    pcie_ss_flr_req_fifo #(.DEPTH(REQ_FIFO_DEPTH), .W(FUNC_W)) u_fifo (
        .clk     (fim_clk),
        .rst_n   (fim_rst_n),
        .push_i  (flr_req_if.tvalid),
        .data_i  (flr_req_if.tdata),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    always_comb begin
        in_assert  = state_q == ASSERT;
        pop        = state_q == IDLE && !empty;
        drop       = flr_req_if.tvalid && full && !pop;
        // hold_cnt saturates so a late ack still satisfies the minimum-hold check.
        ack_exit   = in_assert && (ack_seen_q || afu_flr_rst_ack) && hold_q >= HOLD_MAX;
        to_exit    = in_assert && to_q == TO_MAX && !ack_exit;
        state_d    = pop ? ASSERT : (ack_exit || to_exit) ? RESP : state_q == RESP ? IDLE : state_q;
        tgt_d      = pop ? head : tgt_q;
        hold_d     = pop ? '0 : (in_assert && hold_q != HOLD_MAX) ? hold_q + 1'b1 : hold_q;
        to_d       = pop ? '0 : in_assert ? to_q + 1'b1 : to_q;
        ack_seen_d = pop ? 1'b0 : ack_seen_q || (in_assert && afu_flr_rst_ack);
        ovf_d      = drop || (ovf_q && !clr_stat);
        tmo_d      = to_exit || (tmo_q && !clr_stat);
        tcnt_d     = clr_stat ? {7'd0, to_exit} : (to_exit && tcnt_q != 8'hff) ? tcnt_q + 8'd1 : tcnt_q;
    end

    always_ff @(posedge fim_clk or negedge fim_rst_n) begin
        if (!fim_rst_n) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            hold_q     <= '0;
            to_q       <= '0;
            ack_seen_q <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            hold_q     <= hold_d;
            to_q       <= to_d;
            ack_seen_q <= ack_seen_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign afu_flr_rst_valid     = state_q == ASSERT;
    assign afu_flr_rst_vf_active = tgt_q.vf_active;
    assign afu_flr_rst_pf        = tgt_q.pf;
    assign afu_flr_rst_vf        = tgt_q.vf;
    assign flr_rsp_if.tvalid     = state_q == RESP;
    assign flr_rsp_if.tdata      = tgt_q;
    assign flr_busy              = state_q != IDLE || !empty;
    assign stat_ovf              = ovf_q;
    assign stat_timeout          = tmo_q;
    assign stat_timeout_cnt      = tcnt_q;
endmodule

// File: tb/tb_pcie_ss_flr_responder.sv
// tb_pcie_ss_flr_responder: directed self-checking bench for the FLR responder.
module tb_pcie_ss_flr_responder;
    import pcie_ss_axis_pkg::*;

    logic            fim_clk = 1'b0;
    logic            fim_rst_n = 1'b0;
    t_axis_pcie_flr  flr_req_if;
    t_axis_pcie_flr  flr_rsp_if;
    logic            afu_flr_rst_valid, afu_flr_rst_vf_active;
    logic [PF_W-1:0] afu_flr_rst_pf;
    logic [VF_W-1:0] afu_flr_rst_vf;
    logic            afu_flr_rst_ack = 1'b0;
    logic            flr_busy;
    logic            clr_stat = 1'b0;
    logic            stat_ovf, stat_timeout;
    logic [7:0]      stat_timeout_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rise = -1, last = -1, busy_fall = -1;
    bit prev_rv = 0, prev_busy = 0;
    int rsp_cyc[$];
    t_flr_func rsp_dat[$];

    pcie_ss_flr_responder #(.REQ_FIFO_DEPTH(4), .MIN_RST_CYCLES(16), .ACK_TIMEOUT(64)) dut (
        .fim_clk               (fim_clk),
        .fim_rst_n             (fim_rst_n),
        .flr_req_if            (flr_req_if),
        .flr_rsp_if            (flr_rsp_if),
        .afu_flr_rst_valid     (afu_flr_rst_valid),
        .afu_flr_rst_vf_active (afu_flr_rst_vf_active),
        .afu_flr_rst_pf        (afu_flr_rst_pf),
        .afu_flr_rst_vf        (afu_flr_rst_vf),
        .afu_flr_rst_ack       (afu_flr_rst_ack),
        .flr_busy              (flr_busy),
        .clr_stat              (clr_stat),
        .stat_ovf              (stat_ovf),
        .stat_timeout          (stat_timeout),
        .stat_timeout_cnt      (stat_timeout_cnt)
    );

    always #5 fim_clk = ~fim_clk;
    always @(posedge fim_clk) cyc <= cyc + 1;

    always @(negedge fim_clk) begin
        if (flr_rsp_if.tvalid) begin
            rsp_cyc.push_back(cyc);
            rsp_dat.push_back(flr_rsp_if.tdata);
        end
        if (afu_flr_rst_valid && !prev_rv) rise = cyc;
        if (!afu_flr_rst_valid && prev_rv) last = cyc - 1;
        if (!flr_busy && prev_busy) busy_fall = cyc;
        prev_rv   = afu_flr_rst_valid;
        prev_busy = flr_busy;
    end

    task automatic tick;
        @(posedge fim_clk);
        #1;
    endtask

    task automatic clear_log;
        rsp_cyc.delete();
        rsp_dat.delete();
        rise = -1;
        last = -1;
        busy_fall = -1;
    endtask

    task automatic send(input logic vfa, input int pf, input int vf);
        flr_req_if.tvalid          = 1'b1;
        flr_req_if.tdata.vf_active = vfa;
        flr_req_if.tdata.pf        = PF_W'(pf);
        flr_req_if.tdata.vf        = VF_W'(vf);
        tick;
        flr_req_if = '0;
    endtask

    task automatic wait_rsps(input int n, input int budget);
        int k = 0;
        while (rsp_cyc.size() < n && k < budget) begin
            tick;
            k++;
        end
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({afu_flr_rst_valid, flr_rsp_if.tvalid, flr_busy, stat_ovf, stat_timeout, stat_timeout_cnt} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0", {afu_flr_rst_valid, flr_rsp_if.tvalid, flr_busy, stat_ovf, stat_timeout, stat_timeout_cnt});
        end
        total++;
        if ({afu_flr_rst_pf, afu_flr_rst_vf, afu_flr_rst_vf_active, flr_rsp_if.tdata} !== '0) begin
            bad++;
            $display("FAIL reset_target: got nonzero target want 0");
        end
        tick;
        fim_rst_n = 1'b1;
        repeat (3) tick;
        total++;
        if (flr_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_busy: got %0b want 0", flr_busy);
        end
    endtask

    task automatic test_basic;
        int t0;
        clear_log();
        t0 = cyc;
        send(1'b0, 2, 0);
        while (cyc < t0 + 5) tick;
        afu_flr_rst_ack = 1'b1;
        tick;
        afu_flr_rst_ack = 1'b0;
        wait_rsps(1, 60);
        total++;
        if (rise !== t0 + 2 || last !== t0 + 17) begin
            bad++;
            $display("FAIL basic_rst_window: got %0d..%0d want %0d..%0d", rise - t0, last - t0, 2, 17);
        end
        total++;
        if (rsp_cyc.size() != 1 || rsp_cyc[0] !== t0 + 18) begin
            bad++;
            $display("FAIL basic_rsp_time: got n=%0d want rsp at T+18", rsp_cyc.size());
        end else begin
            total++;
            if (rsp_dat[0].pf !== 3'd2 || rsp_dat[0].vf_active !== 1'b0) begin
                bad++;
                $display("FAIL basic_rsp_data: got pf=%0d vfa=%0b want pf=2 vfa=0", rsp_dat[0].pf, rsp_dat[0].vf_active);
            end
        end
        total++;
        if (stat_timeout !== 1'b0) begin
            bad++;
            $display("FAIL basic_no_timeout: got %0b want 0", stat_timeout);
        end
        repeat (3) tick;
    endtask

    task automatic test_late_ack;
        int t0;
        clear_log();
        t0 = cyc;
        send(1'b1, 0, 37);
        total++;
        tick;
        if (afu_flr_rst_vf !== 11'd37 || afu_flr_rst_vf_active !== 1'b1 || afu_flr_rst_pf !== 3'd0) begin
            bad++;
            $display("FAIL late_target_outputs: got vf=%0d vfa=%0b pf=%0d want vf=37 vfa=1 pf=0", afu_flr_rst_vf, afu_flr_rst_vf_active, afu_flr_rst_pf);
        end
        while (cyc < t0 + 41) tick;
        afu_flr_rst_ack = 1'b1;
        tick;
        afu_flr_rst_ack = 1'b0;
        wait_rsps(1, 40);
        total++;
        if (last - rise + 1 !== 40 || rise !== t0 + 2) begin
            bad++;
            $display("FAIL late_rst_len: got %0d cycles from T+%0d want 40 from T+2", last - rise + 1, rise - t0);
        end
        total++;
        if (rsp_cyc.size() != 1 || rsp_cyc[0] !== t0 + 42) begin
            bad++;
            $display("FAIL late_rsp_time: got n=%0d want one rsp at T+42", rsp_cyc.size());
        end else begin
            total++;
            if (rsp_dat[0].vf !== 11'd37 || rsp_dat[0].vf_active !== 1'b1) begin
                bad++;
                $display("FAIL late_rsp_data: got vf=%0d vfa=%0b want vf=37 vfa=1", rsp_dat[0].vf, rsp_dat[0].vf_active);
            end
        end
        total++;
        if (stat_timeout !== 1'b0) begin
            bad++;
            $display("FAIL late_no_timeout: got %0b want 0", stat_timeout);
        end
        repeat (3) tick;
    endtask

    task automatic test_timeout;
        int t0;
        clear_log();
        t0 = cyc;
        send(1'b1, 1, 5);
        wait_rsps(1, 100);
        total++;
        if (rsp_cyc.size() != 1 || rsp_cyc[0] !== t0 + 66 || last - rise + 1 !== 64) begin
            bad++;
            $display("FAIL timeout_rsp: got n=%0d assert_len=%0d want one rsp after 64 assert cycles", rsp_cyc.size(), last - rise + 1);
        end
        total++;
        if (stat_timeout !== 1'b1 || stat_timeout_cnt !== 8'd1) begin
            bad++;
            $display("FAIL timeout_stats: got to=%0b cnt=%0d want to=1 cnt=1", stat_timeout, stat_timeout_cnt);
        end
        clr_stat = 1'b1;
        tick;
        clr_stat = 1'b0;
        total++;
        if (stat_timeout !== 1'b0 || stat_timeout_cnt !== 8'd0) begin
            bad++;
            $display("FAIL timeout_clr: got to=%0b cnt=%0d want 0 0", stat_timeout, stat_timeout_cnt);
        end
        repeat (3) tick;
    endtask

    task automatic test_overflow;
        int t0;
        clear_log();
        total++;
        if (stat_ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_initial: got %0b want 0", stat_ovf);
        end
        afu_flr_rst_ack = 1'b1;
        t0 = cyc;
        for (int i = 1; i <= 6; i++) send(1'b1, 0, i);
        total++;
        if (stat_ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flag: got %0b want 1", stat_ovf);
        end
        total++;
        if (rise !== t0 + 2) begin
            bad++;
            $display("FAIL ovf_first_pop: got rise T+%0d want T+2", rise - t0);
        end
        wait_rsps(5, 200);
        repeat (40) tick;
        total++;
        if (rsp_cyc.size() != 5) begin
            bad++;
            $display("FAIL ovf_rsp_count: got %0d want 5", rsp_cyc.size());
        end
        for (int i = 0; i < 5 && i < rsp_dat.size(); i++) begin
            total++;
            if (rsp_dat[i].vf !== VF_W'(i + 1)) begin
                bad++;
                $display("FAIL ovf_order[%0d]: got vf=%0d want %0d", i, rsp_dat[i].vf, i + 1);
            end
        end
        afu_flr_rst_ack = 1'b0;
        clr_stat = 1'b1;
        tick;
        clr_stat = 1'b0;
        repeat (2) tick;
    endtask

    task automatic test_back_to_back;
        clear_log();
        afu_flr_rst_ack = 1'b1;
        send(1'b0, 3, 10);
        send(1'b0, 4, 11);
        send(1'b0, 5, 12);
        wait_rsps(3, 120);
        repeat (3) tick;
        total++;
        if (rsp_cyc.size() != 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d want 3", rsp_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (rsp_dat[i].vf !== VF_W'(10 + i) || rsp_dat[i].pf !== PF_W'(3 + i)) begin
                    bad++;
                    $display("FAIL b2b_order[%0d]: got pf=%0d vf=%0d want pf=%0d vf=%0d", i, rsp_dat[i].pf, rsp_dat[i].vf, 3 + i, 10 + i);
                end
            end
            for (int i = 1; i < 3; i++) begin
                total++;
                if (rsp_cyc[i] - rsp_cyc[i-1] < 18) begin
                    bad++;
                    $display("FAIL b2b_gap[%0d]: got %0d want >=18", i, rsp_cyc[i] - rsp_cyc[i-1]);
                end
            end
            total++;
            if (busy_fall !== rsp_cyc[2] + 1) begin
                bad++;
                $display("FAIL b2b_busy_drop: got %0d want %0d", busy_fall, rsp_cyc[2] + 1);
            end
        end
        afu_flr_rst_ack = 1'b0;
        repeat (2) tick;
    endtask

    task automatic test_reset_mid;
        int t0, t1;
        clear_log();
        t0 = cyc;
        send(1'b0, 0, 20);
        send(1'b0, 0, 21);
        send(1'b0, 0, 22);
        while (cyc < t0 + 6) tick;
        total++;
        if (afu_flr_rst_valid !== 1'b1 || flr_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre_state: got rv=%0b busy=%0b want 1 1", afu_flr_rst_valid, flr_busy);
        end
        #2 fim_rst_n = 1'b0;
        #1;
        total++;
        if (afu_flr_rst_valid !== 1'b0 || flr_busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_async_drop: got rv=%0b busy=%0b want 0 0", afu_flr_rst_valid, flr_busy);
        end
        repeat (2) tick;
        fim_rst_n = 1'b1;
        clear_log();
        repeat (40) tick;
        total++;
        if (rsp_cyc.size() != 0 || rise != -1) begin
            bad++;
            $display("FAIL mid_no_rsp: got rsps=%0d rise=%0d want 0 -1", rsp_cyc.size(), rise);
        end
        afu_flr_rst_ack = 1'b1;
        t1 = cyc;
        send(1'b1, 1, 99);
        wait_rsps(1, 60);
        afu_flr_rst_ack = 1'b0;
        total++;
        if (rsp_cyc.size() != 1 || rsp_cyc[0] !== t1 + 18 || rise !== t1 + 2) begin
            bad++;
            $display("FAIL mid_recover_time: got n=%0d rise=T+%0d want one rsp at T+18 rise T+2", rsp_cyc.size(), rise - t1);
        end else begin
            total++;
            if (rsp_dat[0].vf !== 11'd99 || rsp_dat[0].pf !== 3'd1 || rsp_dat[0].vf_active !== 1'b1) begin
                bad++;
                $display("FAIL mid_recover_data: got pf=%0d vf=%0d vfa=%0b want 1 99 1", rsp_dat[0].pf, rsp_dat[0].vf, rsp_dat[0].vf_active);
            end
        end
    endtask

    initial begin
        flr_req_if = '0;
        test_reset();
        test_basic();
        test_late_ack();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
